// File: rtl/predecode_queue.sv
// predecode_queue: classifies fetch words at push time and buffers instr/PC/flags in a show-ahead FIFO
module predecode_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter bit RAS_X5_IS_LINK = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [31:0]                i_instruction,
  input  logic [XLEN-1:0]            i_pc,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [31:0]                o_instruction,
  output logic [XLEN-1:0]            o_pc,
  output logic [16:0]                o_flags,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rd, rs1;
  logic is_op, is_sys, is_amo, is_jal, is_jalr, rd_link, rs1_link, priv;
  logic [16:0] flags_d;
  assign opc = i_instruction[6:0];
  assign f3 = i_instruction[14:12];
  assign rd = i_instruction[11:7];
  assign rs1 = i_instruction[19:15];
  assign is_op = opc == 7'b0110011 && i_instruction[31:25] == 7'b0000001;
  assign is_sys = opc == 7'b1110011;
  assign is_amo = opc == 7'b0101111;
  assign is_jal = opc == 7'b1101111;
  assign is_jalr = opc == 7'b1100111 && f3 == 3'b000;
  assign rd_link = rd == 5'd1 || (RAS_X5_IS_LINK && rd == 5'd5);
  assign rs1_link = rs1 == 5'd1 || (RAS_X5_IS_LINK && rs1 == 5'd5);
  assign priv = is_sys && f3 == 3'b000;
  assign flags_d = {
    (is_jal | is_jalr) & rd_link,
    is_jalr & rs1_link & rd == 5'd0 & i_instruction[31:20] == 12'h000,
    opc == 7'b1100011,
    is_jalr,
    is_jal,
    priv & i_instruction[31:20] == 12'h105,
    priv & i_instruction[31:20] == 12'h302,
    priv & i_instruction[31:20] == 12'h001,
    priv & i_instruction[31:20] == 12'h000,
    is_amo & f3 == 3'b010 & i_instruction[31:27] == 5'b00011,
    is_amo & f3 == 3'b010 & i_instruction[31:27] == 5'b00010,
    is_amo,
    is_sys & f3 != 3'b000,
    is_op & f3[2],
    is_op & ~f3[2],
    opc == 7'b0100011,
    opc == 7'b0000011
  };
  logic [31:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [16:0] flags_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  assign o_ready = count_q != CW'(DEPTH);
  assign o_valid = count_q != '0;
  assign push = i_valid & o_ready & ~i_flush;
  assign pop = o_valid & i_ready & ~i_flush;
  always_comb begin
    wr_d = i_flush ? '0 : wr_q + AW'(push);
    rd_d = i_flush ? '0 : rd_q + AW'(pop);
    count_d = i_flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) begin
      instr_q[wr_q] <= i_instruction;
      pc_q[wr_q] <= i_pc;
      flags_q[wr_q] <= flags_d;
    end
  end
  assign o_instruction = o_valid ? instr_q[rd_q] : '0;
  assign o_pc = o_valid ? pc_q[rd_q] : '0;
  assign o_flags = o_valid ? flags_q[rd_q] : '0;
  assign o_count = count_q;
endmodule

// File: tb/tb_predecode_queue.sv
// tb_predecode_queue: directed vectors for decode flags plus hand sequences for full, streaming, flush and reset
module tb_predecode_queue;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, valid = 1'b0, ready = 1'b0;
  logic [31:0] instr = '0, pc = '0;
  logic a_ready, a_valid, b_ready, b_valid;
  logic [31:0] a_instr, a_pc, b_instr, b_pc;
  logic [16:0] a_flags, b_flags;
  logic [2:0] a_count, b_count;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [31:0] instr;
    logic [16:0] f;
    logic [16:0] fn;
  } vec_t;
  vec_t tbl [20];
  logic [31:0] model [$];
  always #5 clk = ~clk;
  predecode_queue dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(a_ready),
    .i_instruction(instr), .i_pc(pc), .o_valid(a_valid), .i_ready(ready),
    .o_instruction(a_instr), .o_pc(a_pc), .o_flags(a_flags), .o_count(a_count)
  );
  predecode_queue #(.RAS_X5_IS_LINK(1'b0)) dut_nox5 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(b_ready),
    .i_instruction(instr), .i_pc(pc), .o_valid(b_valid), .i_ready(ready),
    .o_instruction(b_instr), .o_pc(b_pc), .o_flags(b_flags), .o_count(b_count)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push_one(input logic [31:0] w, input logic [31:0] p);
    instr = w;
    pc = p;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{32'h00008067, 17'h0A000, 17'h0A000};
    tbl[1]  = '{32'h004000EF, 17'h11000, 17'h11000};
    tbl[2]  = '{32'h0000A283, 17'h00001, 17'h00001};
    tbl[3]  = '{32'h02B50533, 17'h00004, 17'h00004};
    tbl[4]  = '{32'h02B54533, 17'h00008, 17'h00008};
    tbl[5]  = '{32'h00552023, 17'h00002, 17'h00002};
    tbl[6]  = '{32'h30529073, 17'h00010, 17'h00010};
    tbl[7]  = '{32'h00B5202F, 17'h00020, 17'h00020};
    tbl[8]  = '{32'h100522AF, 17'h00060, 17'h00060};
    tbl[9]  = '{32'h18B5232F, 17'h000A0, 17'h000A0};
    tbl[10] = '{32'h00000073, 17'h00100, 17'h00100};
    tbl[11] = '{32'h00100073, 17'h00200, 17'h00200};
    tbl[12] = '{32'h30200073, 17'h00400, 17'h00400};
    tbl[13] = '{32'h10500073, 17'h00800, 17'h00800};
    tbl[14] = '{32'h00B50463, 17'h04000, 17'h04000};
    tbl[15] = '{32'h000282E7, 17'h12000, 17'h02000};
    tbl[16] = '{32'h00028067, 17'h0A000, 17'h02000};
    tbl[17] = '{32'h004080E7, 17'h12000, 17'h12000};
    tbl[18] = '{32'h00408067, 17'h02000, 17'h02000};
    tbl[19] = '{32'h004002EF, 17'h11000, 17'h01000};
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", a_valid, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_count", a_count, 0);
    chk("rst_flags", a_flags, 0);
    chk("rst_instr", a_instr, 0);
    chk("rst_pc", a_pc, 0);
    for (int i = 0; i < 20; i++) begin
      push_one(tbl[i].instr, 32'h1000 + 32'(4 * i));
      chk($sformatf("vec%0d_valid", i), a_valid, 1);
      chk($sformatf("vec%0d_count", i), a_count, 1);
      chk($sformatf("vec%0d_instr", i), a_instr, tbl[i].instr);
      chk($sformatf("vec%0d_pc", i), a_pc, 32'h1000 + 32'(4 * i));
      chk($sformatf("vec%0d_flags", i), a_flags, tbl[i].f);
      chk($sformatf("vec%0d_flags_nox5", i), b_flags, tbl[i].fn);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk($sformatf("vec%0d_empty", i), a_valid, 0);
      chk($sformatf("vec%0d_zero_flags", i), a_flags, 0);
      chk($sformatf("vec%0d_zero_instr", i), a_instr, 0);
    end
    push_one(32'h004000EF, 32'h100);
    push_one(32'h0000A283, 32'h104);
    push_one(32'h02B50533, 32'h108);
    chk("order_count", a_count, 3);
    ready = 1'b1;
    chk("order_f0", a_flags, 17'h11000);
    tick();
    chk("order_f1", a_flags, 17'h00001);
    tick();
    chk("order_f2", a_flags, 17'h00004);
    tick();
    ready = 1'b0;
    chk("order_empty", a_count, 0);
    for (int k = 0; k < 4; k++) push_one(32'h00B50533, 32'h200 + 32'(4 * k));
    chk("full_count", a_count, 4);
    chk("full_ready", a_ready, 0);
    instr = 32'h00B50533;
    pc = 32'h210;
    valid = 1'b1;
    tick();
    chk("full_held", a_count, 4);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("full_pop_count", a_count, 3);
    chk("full_pop_ready", a_ready, 1);
    chk("full_pop_head", a_pc, 32'h204);
    tick();
    valid = 1'b0;
    chk("full_fifth_in", a_count, 4);
    ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("drain_pc%0d", k), a_pc, 32'h200 + 32'(4 * k));
      tick();
    end
    ready = 1'b0;
    chk("drain_empty", a_valid, 0);
    push_one(32'h00B50533, 32'h300);
    push_one(32'h00B50533, 32'h304);
    model = {32'h300, 32'h304};
    for (int c = 0; c < 16; c++) begin
      pc = 32'h308 + 32'(4 * c);
      valid = 1'b1;
      ready = 1'b1;
      chk($sformatf("stream_head%0d", c), a_pc, model[0]);
      tick();
      void'(model.pop_front());
      model.push_back(pc);
      chk($sformatf("stream_count%0d", c), a_count, 2);
    end
    valid = 1'b0;
    ready = 1'b0;
    chk("stream_tail_head", a_pc, model[0]);
    push_one(32'h00B50533, 32'h400);
    chk("flush_pre_count", a_count, 3);
    flush = 1'b1;
    valid = 1'b1;
    ready = 1'b1;
    instr = 32'h02B50533;
    pc = 32'h404;
    tick();
    flush = 1'b0;
    valid = 1'b0;
    ready = 1'b0;
    chk("flush_count", a_count, 0);
    chk("flush_valid", a_valid, 0);
    chk("flush_pc", a_pc, 0);
    chk("flush_flags", a_flags, 0);
    chk("flush_ready", a_ready, 1);
    push_one(32'h004000EF, 32'h408);
    chk("post_flush_pc", a_pc, 32'h408);
    chk("post_flush_count", a_count, 1);
    push_one(32'h0000A283, 32'h40C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_count", a_count, 0);
    chk("midrst_valid", a_valid, 0);
    chk("midrst_instr", a_instr, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
